// File: rtl/regfile_wr_arbiter.sv
// Write-port owner for the 32x32 regfile: arbitrates NUM_REQ writeback sources and zeroes
// x1..x(NUM_REGS-1) after reset or clear_i. Define RF_ARB_FIXED_PRIO_EN for fixed priority.
module regfile_wr_arbiter #(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned DATA_W   = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic                      clear_i,
    output logic                      busy_o,
    output logic                      we3_o,
    output logic [ADDR_W-1:0]         a3_o,
    output logic [DATA_W-1:0]         wd3_o
);

    localparam int unsigned       IDX_W      = $clog2(NUM_REQ);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : gen_bad_num_req
        $error("regfile_wr_arbiter: NUM_REQ must be in 2..8");
    end
    if (NUM_REGS < 2 || NUM_REGS > (1 << ADDR_W)) begin : gen_bad_num_regs
        $error("regfile_wr_arbiter: NUM_REGS must fit in ADDR_W bits");
    end

    typedef enum logic [0:0] {StClr, StArb} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] clr_addr_q;
    logic              we3_q;
    logic [ADDR_W-1:0] a3_q;
    logic [DATA_W-1:0] wd3_q;
`ifndef RF_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]  rr_ptr_q;
`endif

    logic              accept;
    logic [IDX_W-1:0]  cand;
    logic [IDX_W-1:0]  grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              addr_ok;

    // A pending clear wins over all requests in ARB.
    always_comb begin
        accept    = 1'b0;
        cand      = '0;
        grant_idx = '0;
        sel_addr  = '0;
        sel_data  = '0;
        if (state_q == StArb && !clear_i) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef RF_ARB_FIXED_PRIO_EN
                cand = IDX_W'(i);
`else
                cand = IDX_W'((32'(rr_ptr_q) + 32'd1 + i) % NUM_REQ);
`endif
                if (!accept && req_valid_i[cand]) begin
                    accept    = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_addr = req_addr_i[i*ADDR_W +: ADDR_W];
                sel_data = req_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign grant   = accept ? (NUM_REQ'(1) << grant_idx) : '0;
    // x0 is hardwired and out-of-range addresses have no backing register.
    assign addr_ok = (sel_addr != '0) && ({1'b0, sel_addr} < NUM_REGS_W);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StClr;
            clr_addr_q <= ADDR_W'(1);
            we3_q      <= 1'b0;
            a3_q       <= '0;
            wd3_q      <= '0;
`ifndef RF_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            case (state_q)
                StClr: begin
                    we3_q      <= 1'b1;
                    a3_q       <= clr_addr_q;
                    wd3_q      <= '0;
                    clr_addr_q <= clr_addr_q + ADDR_W'(1);
                    if (clr_addr_q == LAST_ADDR) begin
                        state_q <= StArb;
                    end
                end
                StArb: begin
                    we3_q <= 1'b0;
                    if (clear_i) begin
                        state_q    <= StClr;
                        clr_addr_q <= ADDR_W'(1);
                    end else if (accept) begin
`ifndef RF_ARB_FIXED_PRIO_EN
                        rr_ptr_q <= grant_idx;
`endif
                        if (addr_ok) begin
                            we3_q <= 1'b1;
                            a3_q  <= sel_addr;
                            wd3_q <= sel_data;
                        end
                    end
                end
                default: state_q <= StClr;
            endcase
        end
    end

    assign req_ready_o = grant;
    assign busy_o      = (state_q == StClr);
    assign we3_o       = we3_q;
    assign a3_o        = a3_q;
    assign wd3_o       = wd3_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: clear sequence, arbitration order, drops,
// clear/request collision and reset during clear.
module tb_regfile_wr_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 6;
    localparam int DW   = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NREQ-1:0]  valid;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] data;
    logic [NREQ-1:0]  ready;
    logic             clear;
    logic             busy;
    logic             we3;
    logic [AW-1:0]    a3;
    logic [DW-1:0]    wd3;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] rf [64];

    regfile_wr_arbiter #(
        .NUM_REQ  (NREQ),
        .NUM_REGS (32),
        .ADDR_W   (AW),
        .DATA_W   (DW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (valid),
        .req_addr_i  (addr),
        .req_data_i  (data),
        .req_ready_o (ready),
        .clear_i     (clear),
        .busy_o      (busy),
        .we3_o       (we3),
        .a3_o        (a3),
        .wd3_o       (wd3)
    );

    always #5 clk = ~clk;

    // Shadow register file driven by the write port.
    always @(posedge clk) begin
        if (we3) rf[a3] <= wd3;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        valid[i]         = v;
        addr[i*AW +: AW] = a;
        data[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        logic [AW-1:0] ea;
        rst_n = 1'b0;
        clear = 1'b0;
        valid = '0;
        addr  = '0;
        data  = '0;
        tick();
        tick();
        checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL rst_we3: got %b want 0", we3); end
        checks++; if (a3 !== '0) begin errors++; $display("FAIL rst_a3: got %0d want 0", a3); end
        checks++; if (wd3 !== '0) begin errors++; $display("FAIL rst_wd3: got %h want 0", wd3); end
        checks++; if (ready !== '0) begin errors++; $display("FAIL rst_ready: got %b want 000", ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b want 1", busy); end
        rst_n = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            ea = k[AW-1:0];
            checks++;
            if (busy !== 1'b1 || ready !== '0) begin
                errors++; $display("FAIL clr_busy k=%0d: busy=%b ready=%b want 1/000", k, busy, ready);
            end
            tick();
            checks++;
            if (we3 !== 1'b1 || a3 !== ea || wd3 !== '0) begin
                errors++;
                $display("FAIL clr_write k=%0d: we3=%b a3=%0d wd3=%h want 1/%0d/0", k, we3, a3, wd3, ea);
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_done_busy: got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        int e;
        logic [NREQ-1:0] eg;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(10 + i), 32'hA000_0000 + DW'(i));
        for (int c = 0; c < 6; c++) begin
`ifdef RF_ARB_FIXED_PRIO_EN
            e = 0;
`else
            e = c % NREQ;
`endif
            eg = NREQ'(1) << e;
            ea = AW'(10 + e);
            ed = 32'hA000_0000 + DW'(e);
            #1;
            checks++;
            if (ready !== eg) begin errors++; $display("FAIL rr_grant c=%0d: got %b want %b", c, ready, eg); end
            tick();
            checks++;
            if (we3 !== 1'b1 || a3 !== ea || wd3 !== ed) begin
                errors++;
                $display("FAIL rr_write c=%0d: we3=%b a3=%0d wd3=%h want 1/%0d/%h", c, we3, a3, wd3, ea, ed);
            end
        end
        valid = '0;
        #1;
        checks++; if (ready !== '0) begin errors++; $display("FAIL idle_ready: got %b want 000", ready); end
        tick();
`ifdef RF_ARB_FIXED_PRIO_EN
        ea = AW'(10);
        ed = 32'hA000_0000;
`else
        ea = AW'(12);
        ed = 32'hA000_0002;
`endif
        checks++;
        if (we3 !== 1'b0 || a3 !== ea || wd3 !== ed) begin
            errors++;
            $display("FAIL idle_hold: we3=%b a3=%0d wd3=%h want 0/%0d/%h", we3, a3, wd3, ea, ed);
        end
    endtask

    task automatic test_single_write();
        set_req(0, 1'b1, AW'(5), 32'hDEAD_BEEF);
        #1;
        checks++; if (ready !== 3'b001) begin errors++; $display("FAIL single_ready: got %b want 001", ready); end
        tick();
        valid = '0;
        checks++;
        if (we3 !== 1'b1 || a3 !== AW'(5) || wd3 !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL single_write: we3=%b a3=%0d wd3=%h want 1/5/deadbeef", we3, a3, wd3);
        end
        tick();
        checks++; if (rf[5] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rf5: got %h want deadbeef", rf[5]); end
        checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL single_after: we3=%b want 0", we3); end
    endtask

    task automatic test_addr_drop();
        set_req(1, 1'b1, AW'(0), 32'h0000_1234);
        #1;
        checks++; if (ready !== 3'b010) begin errors++; $display("FAIL zero_ready: got %b want 010", ready); end
        tick();
        valid = '0;
        checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL zero_drop: we3=%b want 0", we3); end
        set_req(2, 1'b1, AW'(40), 32'h0000_CAFE);
        #1;
        checks++; if (ready !== 3'b100) begin errors++; $display("FAIL range_ready: got %b want 100", ready); end
        tick();
        valid = '0;
        checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL range_drop: we3=%b want 0", we3); end
        tick();
        checks++; if (rf[0] !== '0) begin errors++; $display("FAIL rf0: got %h want 0", rf[0]); end
        checks++; if (rf[40] !== '0) begin errors++; $display("FAIL rf40: got %h want 0", rf[40]); end
    endtask

    task automatic test_withdraw();
        set_req(0, 1'b1, AW'(9), 32'h0000_0099);
        #1;
        checks++; if (ready !== 3'b001) begin errors++; $display("FAIL wd_ready: got %b want 001", ready); end
        valid = '0;
        #1;
        checks++; if (ready !== '0) begin errors++; $display("FAIL wd_release: got %b want 000", ready); end
        tick();
        checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL wd_nowrite: we3=%b want 0", we3); end
    endtask

    task automatic test_clear_collision();
        logic [AW-1:0] ea;
        set_req(0, 1'b1, AW'(7), 32'h0000_55AA);
        clear = 1'b1;
        #1;
        checks++; if (ready !== '0) begin errors++; $display("FAIL col_ready: got %b want 000", ready); end
        tick();
        clear = 1'b0;
        checks++;
        if (busy !== 1'b1 || we3 !== 1'b0) begin
            errors++; $display("FAIL col_enter: busy=%b we3=%b want 1/0", busy, we3);
        end
        for (int k = 1; k <= 31; k++) begin
            ea = k[AW-1:0];
            checks++;
            if (busy !== 1'b1 || ready !== '0) begin
                errors++; $display("FAIL col_busy k=%0d: busy=%b ready=%b want 1/000", k, busy, ready);
            end
            tick();
            checks++;
            if (we3 !== 1'b1 || a3 !== ea || wd3 !== '0) begin
                errors++;
                $display("FAIL col_clr k=%0d: we3=%b a3=%0d wd3=%h want 1/%0d/0", k, we3, a3, wd3, ea);
            end
        end
        checks++;
        if (busy !== 1'b0 || ready !== 3'b001) begin
            errors++; $display("FAIL col_served: busy=%b ready=%b want 0/001", busy, ready);
        end
        tick();
        valid = '0;
        checks++;
        if (we3 !== 1'b1 || a3 !== AW'(7) || wd3 !== 32'h0000_55AA) begin
            errors++; $display("FAIL col_write: we3=%b a3=%0d wd3=%h want 1/7/55aa", we3, a3, wd3);
        end
        tick();
    endtask

    task automatic test_reset_mid_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        checks++; if (a3 !== AW'(9)) begin errors++; $display("FAIL mid_pos: a3=%0d want 9", a3); end
        rst_n = 1'b0;
        tick();
        checks++;
        if (we3 !== 1'b0 || a3 !== '0 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_rst: we3=%b a3=%0d busy=%b want 0/0/1", we3, a3, busy);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (we3 !== 1'b1 || a3 !== AW'(1)) begin
            errors++; $display("FAIL mid_restart: we3=%b a3=%0d want 1/1", we3, a3);
        end
        for (int k = 0; k < 30; k++) tick();
        checks++;
        if (busy !== 1'b0 || a3 !== AW'(31)) begin
            errors++; $display("FAIL mid_done: busy=%b a3=%0d want 0/31", busy, a3);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rf[i] = '0;
        test_reset();
        test_round_robin();
        test_single_write();
        test_addr_drop();
        test_withdraw();
        test_clear_collision();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
